// File: rtl/rom_download_pkg.sv
// Shared types and defaults for the ROM download controller.
// FIFO entry layout, dispatcher state encoding and BG region defaults.
package rom_download_pkg;

  // First ioctl byte address of the background/sprite region
  localparam logic [24:0] BG_BASE_DEFAULT    = 25'h00E000;
  // Byte length of the background/sprite region
  localparam logic [24:0] BG_SIZE_DEFAULT    = 25'h008000;
  // Byte FIFO entries (power of two, at least 2)
  localparam int          FIFO_DEPTH_DEFAULT = 4;

  // One captured download byte together with its ioctl address
  typedef struct packed {
    logic [24:0] addr;
    logic [7:0]  data;
  } fifo_entry_t;

  // Dispatcher: IDLE pops and issues, WAIT holds until acks match
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } disp_state_t;

endpackage

// File: rtl/rom_download_ctrl_byte_fifo.sv
// Small synchronous FIFO with combinational head output.
// Pointers carry one extra wrap bit; full/empty come from comparing that bit.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module byte_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign empty    = (wr_ptr_reg == rd_ptr_reg);
  assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);
  // Head is read combinationally so the dispatcher can pop and issue in one cycle
  assign pop_data = mem_reg[rd_ptr_reg[AW-1:0]];

  // Pointer update; a push and a pop in the same cycle leave occupancy unchanged
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset since the pointers define validity
  always_ff @(posedge clk_sys) begin
    if (push_ok) mem_reg[wr_ptr_reg[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/rom_download_ctrl.sv
// ROM download controller: ioctl byte stream -> toggle-handshake SDRAM writes.
// Every byte goes to port1 (linear CPU image); bytes in the BG region also go
// to port2, remapped into 32-bit-wide words. rom_loaded rises once the
// download has ended and everything queued has been acknowledged.
// Optional build macro: ROMDL_CHECKSUM_EN adds a 16-bit byte checksum output.
module rom_download_ctrl
  import rom_download_pkg::*;
#(
  parameter logic [24:0] BG_BASE    = BG_BASE_DEFAULT,
  parameter logic [24:0] BG_SIZE    = BG_SIZE_DEFAULT,
  parameter int          FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_downl,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        port1_req,
  input  logic        port1_ack,
  output logic [22:0] port1_a,
  output logic [1:0]  port1_ds,
  output logic [15:0] port1_d,
  output logic        port1_we,
  output logic        port2_req,
  input  logic        port2_ack,
  output logic [13:0] port2_a,
  output logic [1:0]  port2_ds,
  output logic [15:0] port2_d,
  output logic        port2_we,
  output logic        rom_loaded,
  output logic        busy,
`ifdef ROMDL_CHECKSUM_EN
  output logic [15:0] checksum,
`endif
  output logic        overflow
);

  // ---------------- byte capture ----------------
  logic        wr_reg;
  logic        wr_prev_reg;
  logic        downl_reg;
  logic        downl_prev_reg;
  logic [24:0] addr_reg;
  logic [7:0]  data_reg;

  logic        push;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;
  fifo_entry_t push_entry;
  fifo_entry_t head_entry;

  // Register the ioctl inputs; edges are detected on the registered copies
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_reg         <= 1'b0;
      wr_prev_reg    <= 1'b0;
      downl_reg      <= 1'b0;
      downl_prev_reg <= 1'b0;
      addr_reg       <= '0;
      data_reg       <= '0;
    end else begin
      wr_reg         <= ioctl_wr;
      wr_prev_reg    <= wr_reg;
      downl_reg      <= ioctl_downl;
      downl_prev_reg <= downl_reg;
      addr_reg       <= ioctl_addr;
      data_reg       <= ioctl_dout;
    end
  end

  logic downl_rise;
  logic downl_fall;

  assign push       = wr_reg && !wr_prev_reg && downl_reg;
  assign downl_rise = downl_reg && !downl_prev_reg;
  assign downl_fall = downl_prev_reg && !downl_reg;
  assign push_entry = {addr_reg, data_reg};

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fifo_entry_t))
  ) u_fifo (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Sticky drop flag; a push into a full FIFO is fine if a pop frees a slot
  logic overflow_reg;
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      overflow_reg <= 1'b0;
    end else if (push && fifo_full && !pop) begin
      overflow_reg <= 1'b1;
    end
  end

  // ---------------- address decode of the FIFO head ----------------
  logic [25:0] bg_end;
  logic        bg_hit;
  logic [24:0] bg_off;
  logic        unused_bg_off;

  // 26-bit end so a region touching the top of the address space cannot wrap
  assign bg_end        = {1'b0, BG_BASE} + {1'b0, BG_SIZE};
  assign bg_hit        = (head_entry.addr >= BG_BASE) &&
                         ({1'b0, head_entry.addr} < bg_end);
  assign bg_off        = head_entry.addr - BG_BASE;
  assign unused_bg_off = ^bg_off[24:15];

  // ---------------- dispatcher FSM ----------------
  disp_state_t state_reg;
  disp_state_t state_next;
  logic        p2_used_reg;
  logic        acks_done;

  logic        port1_req_reg;
  logic [22:0] port1_a_reg;
  logic [1:0]  port1_ds_reg;
  logic [15:0] port1_d_reg;
  logic        port2_req_reg;
  logic [13:0] port2_a_reg;
  logic [1:0]  port2_ds_reg;
  logic [15:0] port2_d_reg;
  logic        we_reg;

  assign acks_done = (port1_ack == port1_req_reg) &&
                     (!p2_used_reg || (port2_ack == port2_req_reg));

  // Next-state and pop decision
  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (acks_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_sys) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Port registers: load on pop and toggle the request lines; on reset the
  // requests follow the acks so no transaction looks outstanding
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      p2_used_reg   <= 1'b0;
      port1_req_reg <= port1_ack;
      port1_a_reg   <= '0;
      port1_ds_reg  <= '0;
      port1_d_reg   <= '0;
      port2_req_reg <= port2_ack;
      port2_a_reg   <= '0;
      port2_ds_reg  <= '0;
      port2_d_reg   <= '0;
    end else if (pop) begin
      p2_used_reg   <= bg_hit;
      port1_req_reg <= ~port1_req_reg;
      port1_a_reg   <= head_entry.addr[23:1];
      port1_ds_reg  <= {head_entry.addr[0], ~head_entry.addr[0]};
      port1_d_reg   <= {head_entry.data, head_entry.data};
      if (bg_hit) begin
        port2_req_reg <= ~port2_req_reg;
        port2_a_reg   <= {bg_off[12:0], bg_off[14]};
        port2_ds_reg  <= {bg_off[13], ~bg_off[13]};
        port2_d_reg   <= {head_entry.data, head_entry.data};
      end
    end
  end

  // Write enable mirrors the registered download flag
  always_ff @(posedge clk_sys) begin
    if (reset) we_reg <= 1'b0;
    else       we_reg <= ioctl_downl;
  end

  // ---------------- completion tracking ----------------
  logic fall_seen_reg;
  logic rom_loaded_reg;

  // Remember the end of the download, then wait for the queue to drain
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      fall_seen_reg  <= 1'b0;
      rom_loaded_reg <= 1'b0;
    end else begin
      if (downl_fall) fall_seen_reg <= 1'b1;
      if (fall_seen_reg && fifo_empty && (state_reg == IDLE)) rom_loaded_reg <= 1'b1;
    end
  end

`ifdef ROMDL_CHECKSUM_EN
  logic [15:0] checksum_reg;

  // Sum of accepted bytes; restarts with each download, frozen once loaded
  always_ff @(posedge clk_sys) begin
    if (reset || downl_rise) begin
      checksum_reg <= '0;
    end else if (push && (!fifo_full || pop) && !rom_loaded_reg) begin
      checksum_reg <= checksum_reg + {8'h00, data_reg};
    end
  end

  assign checksum = checksum_reg;
`else
  logic unused_downl_rise;
  assign unused_downl_rise = downl_rise;
`endif

  // ---------------- outputs ----------------
  assign port1_req  = port1_req_reg;
  assign port1_a    = port1_a_reg;
  assign port1_ds   = port1_ds_reg;
  assign port1_d    = port1_d_reg;
  assign port1_we   = we_reg;
  assign port2_req  = port2_req_reg;
  assign port2_a    = port2_a_reg;
  assign port2_ds   = port2_ds_reg;
  assign port2_d    = port2_d_reg;
  assign port2_we   = we_reg;
  assign rom_loaded = rom_loaded_reg;
  assign busy       = !fifo_empty || (state_reg == WAIT);
  assign overflow   = overflow_reg;

endmodule

// File: tb/tb_rom_download_ctrl.sv
// Self-checking bench for rom_download_ctrl: table of single-byte transfers
// plus hand-written sequences for stalls, drain, reset in WAIT and checksum.
module tb_rom_download_ctrl;

  logic        clk_sys;
  logic        reset;
  logic        ioctl_downl;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        port1_req;
  logic        port1_ack;
  logic [22:0] port1_a;
  logic [1:0]  port1_ds;
  logic [15:0] port1_d;
  logic        port1_we;
  logic        port2_req;
  logic        port2_ack;
  logic [13:0] port2_a;
  logic [1:0]  port2_ds;
  logic [15:0] port2_d;
  logic        port2_we;
  logic        rom_loaded;
  logic        busy;
  logic        overflow;
`ifdef ROMDL_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  rom_download_ctrl dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .ioctl_downl (ioctl_downl),
    .ioctl_wr    (ioctl_wr),
    .ioctl_addr  (ioctl_addr),
    .ioctl_dout  (ioctl_dout),
    .port1_req   (port1_req),
    .port1_ack   (port1_ack),
    .port1_a     (port1_a),
    .port1_ds    (port1_ds),
    .port1_d     (port1_d),
    .port1_we    (port1_we),
    .port2_req   (port2_req),
    .port2_ack   (port2_ack),
    .port2_a     (port2_a),
    .port2_ds    (port2_ds),
    .port2_d     (port2_d),
    .port2_we    (port2_we),
    .rom_loaded  (rom_loaded),
    .busy        (busy),
`ifdef ROMDL_CHECKSUM_EN
    .checksum    (checksum),
`endif
    .overflow    (overflow)
  );

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  data;
    logic [22:0] p1a;
    logic [1:0]  p1ds;
    logic [15:0] p1d;
    logic        p2;
    logic [13:0] p2a;
    logic [1:0]  p2ds;
  } vec_t;

  vec_t vecs [7];

  task automatic step(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic strobe(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    step(2);
    ioctl_wr   = 1'b0;
    step(1);
  endtask

  task automatic wait_p1(input string name);
    int i;
    i = 0;
    while ((port1_req == port1_ack) && (i < 20)) begin
      step(1);
      i++;
    end
    check(name, 32'(port1_req != port1_ack), 32'd1);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    ioctl_wr = 1'b0;
    step(2);
    reset    = 1'b0;
    step(1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    wait_p1($sformatf("v%0d_p1_toggle", idx));
    check($sformatf("v%0d_p1_a", idx),  32'(port1_a),  32'(v.p1a));
    check($sformatf("v%0d_p1_ds", idx), 32'(port1_ds), 32'(v.p1ds));
    check($sformatf("v%0d_p1_d", idx),  32'(port1_d),  32'(v.p1d));
    check($sformatf("v%0d_we", idx),    32'(port1_we), 32'd1);
    check($sformatf("v%0d_p2_toggle", idx), 32'(port2_req != port2_ack), 32'(v.p2));
    if (v.p2) begin
      check($sformatf("v%0d_p2_a", idx),  32'(port2_a),  32'(v.p2a));
      check($sformatf("v%0d_p2_ds", idx), 32'(port2_ds), 32'(v.p2ds));
      check($sformatf("v%0d_p2_d", idx),  32'(port2_d),  32'(v.p1d));
    end
    step(3);
    port1_ack = port1_req;
    if (v.p2) begin
      step(2);
      check($sformatf("v%0d_busy_wait_p2", idx), 32'(busy), 32'd1);
      port2_ack = port2_req;
    end
    step(2);
    check($sformatf("v%0d_busy_done", idx), 32'(busy), 32'd0);
  endtask

  initial begin
    //            addr          data   p1a         p1ds   p1d        p2    p2a       p2ds
    vecs[0] = '{25'h0000001, 8'hA5, 23'h000000, 2'b10, 16'hA5A5, 1'b0, 14'h0000, 2'b00};
    vecs[1] = '{25'h0010001, 8'h3C, 23'h008000, 2'b10, 16'h3C3C, 1'b1, 14'h0002, 2'b10};
    vecs[2] = '{25'h000DFFF, 8'h11, 23'h006FFF, 2'b10, 16'h1111, 1'b0, 14'h0000, 2'b00};
    vecs[3] = '{25'h000E000, 8'h5A, 23'h007000, 2'b01, 16'h5A5A, 1'b1, 14'h0000, 2'b01};
    vecs[4] = '{25'h0015FFF, 8'hC3, 23'h00AFFF, 2'b10, 16'hC3C3, 1'b1, 14'h3FFF, 2'b10};
    vecs[5] = '{25'h0016000, 8'h77, 23'h00B000, 2'b01, 16'h7777, 1'b0, 14'h0000, 2'b00};
    vecs[6] = '{25'h0012000, 8'h96, 23'h009000, 2'b01, 16'h9696, 1'b1, 14'h0001, 2'b01};

    reset       = 1'b1;
    ioctl_downl = 1'b0;
    ioctl_wr    = 1'b0;
    ioctl_addr  = '0;
    ioctl_dout  = '0;
    port1_ack   = 1'b1;
    port2_ack   = 1'b0;
    step(3);

    // Reset state: requests follow acks, everything else idle
    check("rst_p1_req",     32'(port1_req),  32'd1);
    check("rst_p2_req",     32'(port2_req),  32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_rom_loaded", 32'(rom_loaded), 32'd0);
    check("rst_overflow",   32'(overflow),   32'd0);
    check("rst_we",         32'(port1_we),   32'd0);
    check("rst_p1_a",       32'(port1_a),    32'd0);
    check("rst_p1_d",       32'(port1_d),    32'd0);
    check("rst_p2_a",       32'(port2_a),    32'd0);
    reset = 1'b0;
    step(1);

    // Table of single-byte transfers
    ioctl_downl = 1'b1;
    step(2);
    for (int i = 0; i < 7; i++) begin
      strobe(vecs[i].addr, vecs[i].data);
      run_vec(vecs[i], i);
    end

    // Stalled acks: one in flight, four queued, sixth dropped
    for (int k = 0; k < 6; k++) begin
      strobe(25'h100 + 25'(k), 8'h10 + 8'(k));
      if (k == 4) check("stall_no_ovf_yet", 32'(overflow), 32'd0);
    end
    check("stall_ovf",  32'(overflow), 32'd1);
    check("stall_busy", 32'(busy),     32'd1);
    for (int k = 0; k < 5; k++) begin
      logic [7:0] db;
      db = 8'h10 + 8'(k);
      wait_p1($sformatf("stall%0d_toggle", k));
      check($sformatf("stall%0d_a", k),  32'(port1_a),  32'h80 + 32'(k / 2));
      check($sformatf("stall%0d_ds", k), 32'(port1_ds), (k % 2 == 1) ? 32'd2 : 32'd1);
      check($sformatf("stall%0d_d", k),  32'(port1_d),  32'({db, db}));
      step(2);
      port1_ack = port1_req;
      step(1);
    end
    step(4);
    check("stall_no_extra", 32'(port1_req == port1_ack), 32'd1);
    check("stall_idle",     32'(busy), 32'd0);
    check("stall_ovf_sticky", 32'(overflow), 32'd1);

    // Drain: download ends with three bytes queued behind one in flight
    do_reset();
    check("drain_ovf_cleared", 32'(overflow), 32'd0);
    ioctl_downl = 1'b1;
    step(2);
    for (int k = 0; k < 4; k++) strobe(25'h200 + 25'(k), 8'h20 + 8'(k));
    ioctl_downl = 1'b0;
    step(3);
    check("drain_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 4; k++) begin
      wait_p1($sformatf("drain%0d_toggle", k));
      check($sformatf("drain%0d_a", k), 32'(port1_a), 32'h100 + 32'(k / 2));
      check($sformatf("drain%0d_not_loaded", k), 32'(rom_loaded), 32'd0);
      step(2);
      port1_ack = port1_req;
      step(1);
    end
    begin
      int i;
      i = 0;
      while (!rom_loaded && i < 10) begin
        step(1);
        i++;
      end
    end
    check("drain_loaded", 32'(rom_loaded), 32'd1);
    step(5);
    check("drain_loaded_sticky", 32'(rom_loaded), 32'd1);
    check("drain_we_low", 32'(port1_we), 32'd0);

    // Reset while WAIT has both requests outstanding
    ioctl_downl = 1'b1;
    step(2);
    strobe(25'h00E010, 8'h42);
    wait_p1("rstw_p1_toggle");
    check("rstw_p2_toggle", 32'(port2_req != port2_ack), 32'd1);
    do_reset();
    check("rstw_p1_req_eq", 32'(port1_req == port1_ack), 32'd1);
    check("rstw_p2_req_eq", 32'(port2_req == port2_ack), 32'd1);
    check("rstw_busy",      32'(busy),       32'd0);
    check("rstw_loaded",    32'(rom_loaded), 32'd0);
    step(6);
    check("rstw_p1_quiet",  32'(port1_req == port1_ack), 32'd1);
    check("rstw_p2_quiet",  32'(port2_req == port2_ack), 32'd1);

`ifdef ROMDL_CHECKSUM_EN
    // Checksum over a short download
    ioctl_downl = 1'b0;
    do_reset();
    check("csum_reset", 32'(checksum), 32'd0);
    ioctl_downl = 1'b1;
    step(2);
    begin
      logic [7:0] cbytes [3];
      cbytes[0] = 8'hFF;
      cbytes[1] = 8'h01;
      cbytes[2] = 8'h80;
      for (int k = 0; k < 3; k++) begin
        strobe(25'h300 + 25'(k), cbytes[k]);
        wait_p1($sformatf("csum%0d_toggle", k));
        step(1);
        port1_ack = port1_req;
        step(2);
      end
    end
    check("csum_value", 32'(checksum), 32'h0180);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
